ids_bus_matrix: RTL and testbench
=================================

// Module: ids_bus_matrix
// PURPOSE
//  Parametrised shared bus: N_MST masters (core DMEM, DMA, ...) share one bus to N_SLV slaves.
//  Registered arbiter with grant lock; address-region decode from a parameter table.
//  Read data and response valid are routed back to the issuing master one cycle later.
//  Sits between the core/DMA masters and the DMEM, buffer, UART and PIM slaves.
// PARAMETERS
//  N_MST    2              number of masters; index 0 = highest fixed priority
//  N_SLV    4              number of slaves
//  AW       32             address width
//  DW       32             data width
//  SEL_LSB  28             LSB of the 4-bit region field addr[SEL_LSB+3:SEL_LSB]
//  SLV_SEL  {4'h4,4'h8,4'h2,4'h0}  packed N_SLV x 4 region codes; slave s owns SLV_SEL[s]
//  DEF_SLV  0              slave taking region misses
// PORTS
//  i_clk      in   1              clock
//  i_rst      in   1              asynchronous reset, active-high
//  i_m_req    in   [N_MST]        master bus request
//  o_m_gnt    out  [N_MST]        grant, one-hot or zero
//  i_m_addr   in   [N_MST][AW]    master address
//  i_m_write  in   [N_MST]        write strobe
//  i_m_read   in   [N_MST]        read strobe
//  i_m_size   in   [N_MST][4]     byte enables
//  i_m_din    in   [N_MST][DW]    write data
//  o_m_dout   out  [N_MST][DW]    read data, valid only with o_m_rvalid
//  o_m_rvalid out  [N_MST]        read data valid, 1-cycle pulse
//  o_m_err    out  [N_MST]        decode-miss pulse, same cycle as rvalid timing
//  o_s_addr/o_s_write/o_s_read/o_s_size/o_s_din  out [N_SLV][..]  slave request fields
//  i_s_dout   in   [N_SLV][DW]    slave read data, 1 cycle after read strobe
// BEHAVIOUR
//  - Reset: o_m_gnt=0, o_m_rvalid=0, o_m_err=0, owner/route registers=0.
//    All slave outputs are 0 while no grant is held.
//  - States: IDLE (no owner), OWNED (owner=k). Owner is registered.
//  - IDLE and any req: pick the winner. Next cycle o_m_gnt[winner]=1 and state=OWNED.
//    Grant latency is 1 cycle.
//  - OWNED: grant is held while i_m_req[owner]=1, with no preemption by higher-priority masters.
//  - Owner drops req: the grant drops next cycle. Arbitration among the remaining reqs happens
//    in that same cycle, so the new grant appears 1 cycle after the drop.
//  - Only the granted master's fields are forwarded, combinationally, to the single decoded slave.
//    Other slaves see all-zero fields.
//  - Non-owner strobes are ignored.
//  - Decode: slave s is selected when addr[SEL_LSB+3:SEL_LSB]==SLV_SEL[s]. On a miss the access
//    goes to DEF_SLV and o_m_err[owner] pulses 1 cycle later.
//  - Read return: on a granted read, latch {owner, slave idx}. Next cycle:
//    o_m_dout[owner]=i_s_dout[idx] and o_m_rvalid[owner]=1. Other masters' dout=0.
//  - Back-to-back reads return in order, one per cycle. Writes produce no rvalid.
//  - Read in the cycle the grant drops: data is still returned, because routing uses the
//    latched owner.
//  - Simultaneous read and write strobes: both are forwarded; the slave resolves them.
//  - Reset mid-transfer: all state is cleared immediately and a pending rvalid is discarded.
// CONFIGURATION
//  IDS_BUS_RR_EN defined: round-robin arbitration. The pointer advances to owner+1 mod N_MST
//    on release, and the search starts at the pointer. The pointer resets to 0.
//  IDS_BUS_RR_EN undefined: fixed priority, lowest index wins. No pointer logic.
// STRUCTURE
//  - Package ids_bus_pkg holds region-code localparams (REG_DMEM=4'h0, REG_BUF=4'h2,
//    REG_PIM=4'h4, REG_UART=4'h8), the arb_state_e enum {IDLE, OWNED}, and function
//    clog2-safe idx width.
//  - Sub-module ids_bus_arb (N parameter) holds state, owner, pointer and the gnt vector.
//  - Decode, mux and return routing live in ids_bus_matrix.
// TESTING
//  1. Reset asserted mid-read with i_rst=1 -> gnt=0, rvalid=0 in the same cycle; no stale
//     dout after release.
//  2. M0 and M1 req together from IDLE, fixed priority -> cycle+1 gnt=2'b01; M1 is granted
//     1 cycle after M0 drops req.
//  3. M1 owns the bus when M0 raises req -> M1 keeps the grant until its req drops
//     (no preemption).
//  4. M0 read addr 0x8000_0010 -> o_s_read[UART slave]=1. Next cycle o_m_dout[0]=UART dout,
//     rvalid[0]=1, rvalid[1]=0.
//  5. M1 read 0x6000_0000 (miss) -> forwarded to DEF_SLV; err[1]=1 and rvalid[1]=1 one cycle
//     later.
//  6. IDS_BUS_RR_EN: M0 and M1 req continuously with 1-cycle release gaps -> grants alternate
//     0,1,0,1.

Source files
------------

// File: rtl/ids_bus_pkg.sv
// Shared definitions for the ids bus matrix: region codes, arbiter state
// encoding and an index-width helper that stays at least one bit wide.
package ids_bus_pkg;

    localparam logic [3:0] REG_DMEM = 4'h0;
    localparam logic [3:0] REG_BUF  = 4'h2;
    localparam logic [3:0] REG_PIM  = 4'h4;
    localparam logic [3:0] REG_UART = 4'h8;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ids_bus_arb.sv
// Registered bus arbiter with grant lock. Fixed priority (index 0 first) by
// default; define IDS_BUS_RR_EN for round-robin starting at a rotating pointer.
module ids_bus_arb
    import ids_bus_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = idx_w(N)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [N-1:0]  i_req,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_owner,
    output arb_state_e    o_state
);

    arb_state_e    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] winner;
    logic          found;
    logic          release_now;

    assign release_now = (state_q == OWNED) && !i_req[owner_q];

`ifdef IDS_BUS_RR_EN
    logic [IW-1:0] ptr_q, ptr_d;
    logic [IW-1:0] cand;

    // The pointer moves past the releasing owner before the search uses it.
    always_comb begin
        ptr_d = ptr_q;
        if (release_now) begin
            ptr_d = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;
        end
    end

    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int i = 0; i < N; i++) begin
            cand = IW'((int'(ptr_d) + i) % N);
            if (!found && i_req[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end
`else
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < N; i++) begin
            if (!found && i_req[i]) begin
                found  = 1'b1;
                winner = IW'(i);
            end
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        gnt_d   = gnt_q;
        if (state_q == IDLE || release_now) begin
            gnt_d = '0;
            if (found) begin
                state_d        = OWNED;
                owner_d        = winner;
                gnt_d[winner]  = 1'b1;
            end else begin
                state_d = IDLE;
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            gnt_q   <= '0;
`ifdef IDS_BUS_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            gnt_q   <= gnt_d;
`ifdef IDS_BUS_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign o_gnt   = gnt_q;
    assign o_owner = owner_q;
    assign o_state = state_q;

endmodule

// File: rtl/ids_bus_matrix.sv
// Shared bus from N_MST masters to N_SLV region-decoded slaves with registered
// read return. Arbitration becomes round-robin when IDS_BUS_RR_EN is defined.
module ids_bus_matrix
    import ids_bus_pkg::*;
#(
    parameter int                 N_MST   = 2,
    parameter int                 N_SLV   = 4,
    parameter int                 AW      = 32,
    parameter int                 DW      = 32,
    parameter int                 SEL_LSB = 28,
    parameter logic [N_SLV*4-1:0] SLV_SEL = {REG_PIM, REG_UART, REG_BUF, REG_DMEM},
    parameter int                 DEF_SLV = 0
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_MST-1:0]            i_m_req,
    output logic [N_MST-1:0]            o_m_gnt,
    input  logic [N_MST-1:0][AW-1:0]    i_m_addr,
    input  logic [N_MST-1:0]            i_m_write,
    input  logic [N_MST-1:0]            i_m_read,
    input  logic [N_MST-1:0][3:0]       i_m_size,
    input  logic [N_MST-1:0][DW-1:0]    i_m_din,
    output logic [N_MST-1:0][DW-1:0]    o_m_dout,
    output logic [N_MST-1:0]            o_m_rvalid,
    output logic [N_MST-1:0]            o_m_err,
    output logic [N_SLV-1:0][AW-1:0]    o_s_addr,
    output logic [N_SLV-1:0]            o_s_write,
    output logic [N_SLV-1:0]            o_s_read,
    output logic [N_SLV-1:0][3:0]       o_s_size,
    output logic [N_SLV-1:0][DW-1:0]    o_s_din,
    input  logic [N_SLV-1:0][DW-1:0]    i_s_dout,
    output arb_state_e                  o_dbg_state
);

    // Handshake: a master keeps req high for as long as it wants the bus; gnt
    // rises one cycle after it wins, strobes count only while gnt is high, and
    // read data returns with a one-cycle rvalid pulse the cycle after the strobe.

    localparam int MW = idx_w(N_MST);
    localparam int SW = idx_w(N_SLV);

    logic [MW-1:0] owner;
    logic          held;
    logic [AW-1:0] sel_addr;
    logic          sel_write;
    logic          sel_read;
    logic [3:0]    sel_size;
    logic [DW-1:0] sel_din;
    logic [SW-1:0] slv_idx;
    logic          miss;

    logic          ret_rd_q;
    logic          ret_err_q;
    logic [MW-1:0] ret_owner_q;
    logic [SW-1:0] ret_slv_q;

    ids_bus_arb #(
        .N  (N_MST),
        .IW (MW)
    ) u_arb (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_m_req),
        .o_gnt   (o_m_gnt),
        .o_owner (owner),
        .o_state (o_dbg_state)
    );

    assign held      = |o_m_gnt;
    assign sel_addr  = i_m_addr[owner];
    assign sel_write = i_m_write[owner];
    assign sel_read  = i_m_read[owner];
    assign sel_size  = i_m_size[owner];
    assign sel_din   = i_m_din[owner];

    // Walk downwards so the lowest-numbered slave wins if two share a code.
    always_comb begin
        slv_idx = SW'(DEF_SLV);
        miss    = 1'b1;
        for (int s = N_SLV - 1; s >= 0; s--) begin
            if (sel_addr[SEL_LSB +: 4] == SLV_SEL[s*4 +: 4]) begin
                slv_idx = SW'(s);
                miss    = 1'b0;
            end
        end
    end

    always_comb begin
        o_s_addr  = '0;
        o_s_write = '0;
        o_s_read  = '0;
        o_s_size  = '0;
        o_s_din   = '0;
        for (int s = 0; s < N_SLV; s++) begin
            if (held && slv_idx == SW'(s)) begin
                o_s_addr[s]  = sel_addr;
                o_s_write[s] = sel_write;
                o_s_read[s]  = sel_read;
                o_s_size[s]  = sel_size;
                o_s_din[s]   = sel_din;
            end
        end
    end

    // Latching the owner here lets a read issued as the grant drops still return.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            ret_rd_q    <= 1'b0;
            ret_err_q   <= 1'b0;
            ret_owner_q <= '0;
            ret_slv_q   <= '0;
        end else begin
            ret_rd_q  <= held && sel_read;
            ret_err_q <= held && (sel_read || sel_write) && miss;
            if (held && (sel_read || sel_write)) begin
                ret_owner_q <= owner;
                ret_slv_q   <= slv_idx;
            end
        end
    end

    always_comb begin
        o_m_rvalid = '0;
        o_m_err    = '0;
        o_m_dout   = '0;
        for (int m = 0; m < N_MST; m++) begin
            if (ret_owner_q == MW'(m)) begin
                o_m_rvalid[m] = ret_rd_q;
                o_m_err[m]    = ret_err_q;
                if (ret_rd_q) begin
                    o_m_dout[m] = i_s_dout[ret_slv_q];
                end
            end
        end
    end

endmodule

// File: tb/tb_ids_bus_matrix.sv
// Self-checking bench for ids_bus_matrix: directed scenarios followed by random
// traffic, all checked against a cycle-level reference model of the bus rules.
module tb_ids_bus_matrix;
    import ids_bus_pkg::*;

    localparam int N_MST = 2;
    localparam int N_SLV = 4;
    localparam int AW    = 32;
    localparam int DW    = 32;

    // clock / reset
    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [N_MST-1:0]         m_req;
    logic [N_MST-1:0]         m_gnt;
    logic [N_MST-1:0][AW-1:0] m_addr;
    logic [N_MST-1:0]         m_write;
    logic [N_MST-1:0]         m_read;
    logic [N_MST-1:0][3:0]    m_size;
    logic [N_MST-1:0][DW-1:0] m_din;
    logic [N_MST-1:0][DW-1:0] m_dout;
    logic [N_MST-1:0]         m_rvalid;
    logic [N_MST-1:0]         m_err;
    logic [N_SLV-1:0][AW-1:0] s_addr;
    logic [N_SLV-1:0]         s_write;
    logic [N_SLV-1:0]         s_read;
    logic [N_SLV-1:0][3:0]    s_size;
    logic [N_SLV-1:0][DW-1:0] s_din;
    logic [N_SLV-1:0][DW-1:0] s_dout;
    arb_state_e               dbg_state;

    ids_bus_matrix dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_m_req     (m_req),
        .o_m_gnt     (m_gnt),
        .i_m_addr    (m_addr),
        .i_m_write   (m_write),
        .i_m_read    (m_read),
        .i_m_size    (m_size),
        .i_m_din     (m_din),
        .o_m_dout    (m_dout),
        .o_m_rvalid  (m_rvalid),
        .o_m_err     (m_err),
        .o_s_addr    (s_addr),
        .o_s_write   (s_write),
        .o_s_read    (s_read),
        .o_s_size    (s_size),
        .o_s_din     (s_din),
        .i_s_dout    (s_dout),
        .o_dbg_state (dbg_state)
    );

    // reference model state and scoreboard
    int         m_owner = -1;
    int         m_ptr   = 0;
    logic [7:0] exp_q[$];
    int         passed  = 0;
    int         total   = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // region code -> slave index, -1 when no slave owns the region
    function automatic int region_slave(input logic [3:0] r);
        case (r)
            4'h0:    return 0;
            4'h2:    return 1;
            4'h8:    return 2;
            4'h4:    return 3;
            default: return -1;
        endcase
    endfunction

    // driver tasks
    task automatic set_m(input int m, input logic req, input logic rd, input logic wr,
                         input logic [AW-1:0] addr);
        m_req[m]   = req;
        m_read[m]  = rd;
        m_write[m] = wr;
        m_addr[m]  = addr;
        m_size[m]  = 4'($urandom_range(0, 15));
        m_din[m]   = $urandom();
    endtask

    task automatic clear_inputs();
        m_req   = '0;
        m_read  = '0;
        m_write = '0;
        m_addr  = '0;
        m_size  = '0;
        m_din   = '0;
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        exp_q.delete();
    endtask

    // One bus cycle: inputs for the cycle are already applied by the caller.
    task automatic step();
        logic [N_MST-1:0]         e_gnt;
        logic [N_SLV-1:0][AW-1:0] e_sa;
        logic [N_SLV-1:0][DW-1:0] e_sd;
        logic [N_SLV-1:0][3:0]    e_sz;
        logic [N_SLV-1:0]         e_sr;
        logic [N_SLV-1:0]         e_sw;
        logic [N_MST-1:0]         e_rv;
        logic [N_MST-1:0]         e_er;
        logic [N_MST-1:0][DW-1:0] e_do;
        logic [7:0]               e;
        int                       slv;
        int                       start;
        bit                       miss;
        for (int s = 0; s < N_SLV; s++) s_dout[s] = $urandom();
        #1;
        e_gnt = '0;
        if (m_owner >= 0) e_gnt[m_owner] = 1'b1;
        check("gnt", m_gnt, e_gnt);
        check("state", dbg_state, (m_owner >= 0) ? OWNED : IDLE);

        e_sa = '0; e_sd = '0; e_sz = '0; e_sr = '0; e_sw = '0;
        slv  = 0;
        miss = 1'b0;
        if (m_owner >= 0) begin
            slv  = region_slave(m_addr[m_owner][31:28]);
            miss = (slv < 0);
            if (miss) slv = 0;
            e_sa[slv] = m_addr[m_owner];
            e_sd[slv] = m_din[m_owner];
            e_sz[slv] = m_size[m_owner];
            e_sr[slv] = m_read[m_owner];
            e_sw[slv] = m_write[m_owner];
        end
        check("s_addr", s_addr, e_sa);
        check("s_din", s_din, e_sd);
        check("s_size", s_size, e_sz);
        check("s_read", s_read, e_sr);
        check("s_write", s_write, e_sw);

        e_rv = '0; e_er = '0; e_do = '0;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (e[6]) begin
                e_rv[int'(e[5:3])] = 1'b1;
                e_do[int'(e[5:3])] = s_dout[int'(e[2:0])];
            end
            if (e[7]) e_er[int'(e[5:3])] = 1'b1;
        end
        check("rvalid", m_rvalid, e_rv);
        check("err", m_err, e_er);
        check("dout", m_dout, e_do);

        if (m_owner >= 0 && (m_read[m_owner] || m_write[m_owner]))
            exp_q.push_back({miss, m_read[m_owner], 3'(m_owner), 3'(slv)});

        // grant rules: hold while owner requests, otherwise re-arbitrate
        if (m_owner < 0 || !m_req[m_owner]) begin
            start = 0;
`ifdef IDS_BUS_RR_EN
            if (m_owner >= 0) m_ptr = (m_owner + 1) % N_MST;
            start = m_ptr;
`endif
            m_owner = -1;
            for (int i = 0; i < N_MST; i++) begin
                if (m_owner < 0 && m_req[(start + i) % N_MST]) m_owner = (start + i) % N_MST;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int prev;
        clear_inputs();
        s_dout = '0;
        rst    = 1'b1;
        model_reset();
        #2;
        check("rst_gnt", m_gnt, 2'b00);
        check("rst_rvalid", m_rvalid, 2'b00);
        check("rst_err", m_err, 2'b00);
        check("rst_s_read", s_read, 4'b0000);
        check("rst_state", dbg_state, IDLE);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // simultaneous request from idle: M0 wins
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        check("t2_gnt_m0", m_gnt, 2'b01);

        // M0 read of the UART region
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h8000_0010);
        #1;
        check("t4_uart_read", s_read, 4'b0100);
        step();
        check("t4_rvalid", m_rvalid, 2'b01);

        // M0 drops, M1 takes over on the next edge
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("t2_handoff", m_gnt, 2'b10);

        // M0 asks again while M1 holds the bus: no preemption
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t3_lock", m_gnt, 2'b10);
        end

        // M1 read in an unmapped region goes to the default slave and errors
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h6000_0000);
        #1;
        check("t5_def_slave", s_read, 4'b0001);
        step();
        check("t5_err", m_err, 2'b10);
        check("t5_rvalid", m_rvalid, 2'b10);

        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0);
        step();
        check("t3_release", m_gnt, 2'b01);

        // read+write issued in the cycle M0 releases the bus still returns
        set_m(0, 1'b0, 1'b1, 1'b1, 32'h2000_0004);
        step();
        check("drop_rvalid", m_rvalid, 2'b01);
        check("drop_gnt", m_gnt, 2'b00);
        clear_inputs();
        step();

        // both masters request, owner releases for a single cycle each time
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
        set_m(1, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        for (int i = 0; i < 6; i++) begin
            prev = m_owner;
            set_m(prev, 1'b0, 1'b0, 1'b0, 32'h0);
            step();
            check("t6_alt", m_gnt, (prev == 0) ? 2'b10 : 2'b01);
            set_m(prev, 1'b1, 1'b0, 1'b0, 32'h0);
            step();
        end

        // random traffic
        for (int n = 0; n < 400; n++) begin
            for (int m = 0; m < N_MST; m++) begin
                logic [3:0] reg_code;
                case ($urandom_range(0, 5))
                    0:       reg_code = 4'h0;
                    1:       reg_code = 4'h2;
                    2:       reg_code = 4'h4;
                    3:       reg_code = 4'h8;
                    4:       reg_code = 4'h6;
                    default: reg_code = 4'hF;
                endcase
                set_m(m, ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) == 0),
                      ($urandom_range(0, 2) == 0), {reg_code, 28'($urandom())});
            end
            step();
        end

        // reset while a read return is on the bus
        clear_inputs();
        step();
        set_m(0, 1'b1, 1'b0, 1'b0, 32'h0);
        step();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h4000_0000);
        step();
        check("t1_pre_rvalid", m_rvalid, 2'b01);
        rst = 1'b1;
        #1;
        check("t1_gnt", m_gnt, 2'b00);
        check("t1_rvalid", m_rvalid, 2'b00);
        check("t1_dout", m_dout, 64'h0);
        check("t1_state", dbg_state, IDLE);
        model_reset();
        clear_inputs();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
